// File: rtl/udp_stream_arbiter.sv
// Packet-granular round-robin merge of NUM_IN AXI-Stream inputs onto one registered output.
// Define ARB_TIMEOUT_EN to force-close a granted packet whose source stalls for TIMEOUT_CYC cycles.
module udp_stream_arbiter #(
    parameter int NUM_IN      = 4,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_IN*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_IN-1:0]        s_axis_tvalid,
    output logic [NUM_IN-1:0]        s_axis_tready,
    input  logic [NUM_IN-1:0]        s_axis_tlast,
    input  logic [NUM_IN-1:0]        s_axis_tuser,
    output logic [DATA_W-1:0]        m_axis_tdata,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    output logic                     m_axis_tuser,
    input  logic                     m_axis_tready,
    output logic [NUM_IN-1:0]        grant,
    output logic                     timeout_pulse
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_IN) s = s - NUM_IN;
        return PTR_W'(s);
    endfunction

    logic [0:0]        state_q, state_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]  g_q, g_d;
    logic [NUM_IN-1:0] grant_q, grant_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic              m_user_q, m_user_d;

    logic              load_en;
    logic              accept;
    logic              force_close;
    logic              sel_found;
    logic [PTR_W-1:0]  sel_idx;
    logic [DATA_W-1:0] g_data;
    logic              g_valid, g_last, g_user;

    assign g_data  = s_axis_tdata[g_q*DATA_W +: DATA_W];
    assign g_valid = s_axis_tvalid[g_q];
    assign g_last  = s_axis_tlast[g_q];
    assign g_user  = s_axis_tuser[g_q];

    assign load_en = !m_valid_q || m_axis_tready;
    assign accept  = (state_q == S_XFER) && g_valid && load_en;

    // First valid input strictly after the last-served one, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = rr_ptr_q;
        for (int k = 1; k <= NUM_IN; k++) begin
            if (!sel_found && s_axis_tvalid[wrap_add(rr_ptr_q, k)]) begin
                sel_found = 1'b1;
                sel_idx   = wrap_add(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        s_axis_tready = '0;
        if (state_q == S_XFER) s_axis_tready[g_q] = load_en;
    end

`ifdef ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_pulse_q;
    logic        stall;

    assign stall       = (state_q == S_XFER) && !g_valid && load_en;
    assign force_close = stall && (tmo_cnt_q == 16'(TIMEOUT_CYC - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if ((state_q != S_XFER) || accept || force_close) tmo_cnt_d = '0;
        else if (stall)                                   tmo_cnt_d = tmo_cnt_q + 16'd1;
    end

    // Pulse is registered so it lines up with the forced beat on the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q   <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_pulse_q <= force_close;
        end
    end

    assign timeout_pulse = tmo_pulse_q;
`else
    assign force_close   = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        g_d       = g_q;
        grant_d   = grant_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        m_user_d  = m_user_q;

        if (load_en) begin
            m_valid_d = accept || force_close;
            if (accept) begin
                m_data_d = g_data;
                m_last_d = g_last;
                m_user_d = g_user;
            end else if (force_close) begin
                m_data_d = '0;
                m_last_d = 1'b1;
                m_user_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    g_d     = sel_idx;
                    grant_d = NUM_IN'(1) << sel_idx;
                    state_d = S_XFER;
                end
            end
            default: begin
                if ((accept && g_last) || force_close) begin
                    rr_ptr_d = g_q;
                    grant_d  = '0;
                    state_d  = S_IDLE;
                end
            end
        endcase
    end

    // rr_ptr resets to the last input so input 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= PTR_W'(NUM_IN - 1);
            g_q       <= '0;
            grant_q   <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            m_user_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            g_q       <= g_d;
            grant_q   <= grant_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            m_user_q  <= m_user_d;
        end
    end

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign m_axis_tuser  = m_user_q;
    assign grant         = grant_q;

endmodule

// File: tb/tb_udp_stream_arbiter.sv
// Bench for udp_stream_arbiter: per-input packet queues drive the DUT, a scoreboard holds the
// expected merged beat order derived from round-robin packet order.
module tb_udp_stream_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] s_tdata = '0;
    logic [N-1:0]   s_tvalid = '0;
    logic [N-1:0]   s_tready;
    logic [N-1:0]   s_tlast = '0;
    logic [N-1:0]   s_tuser = '0;
    logic [W-1:0]   m_tdata;
    logic           m_tvalid;
    logic           m_tlast;
    logic           m_tuser;
    logic           m_tready = 1'b1;
    logic [N-1:0]   grant;
    logic           timeout_pulse;

    udp_stream_arbiter #(.NUM_IN(N), .DATA_W(W), .TIMEOUT_CYC(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast),
        .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .grant(grant), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    // beat = {tuser, tlast, tdata}
    typedef logic [33:0] beat_t;

    beat_t inq [N][$];
    beat_t expq[$];
    beat_t outlog[$];
    int    out_cyc[$];

    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    int    tmo_n = 0;
    int    in_acc_cyc = 0;
    int    in1_left_snap = 0;
    logic  rnd_ready = 1'b0;
    logic  stall_prev = 1'b0;
    beat_t prev_beat = '0;
    logic [N-1:0] rdy_snap = '0;
    logic [N-1:0] grant_snap = '0;

    function automatic beat_t mk(input logic u, input logic l, input logic [31:0] d);
        return {u, l, d};
    endfunction

    function automatic int pending();
        int s;
        s = expq.size();
        for (int i = 0; i < N; i++) s += inq[i].size();
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        logic [N-1:0] acc;
        beat_t        cur;
        beat_t        expb;
        for (int i = 0; i < N; i++) begin
            if (inq[i].size() > 0) begin
                s_tvalid[i]         = 1'b1;
                s_tdata[i*W +: W]   = inq[i][0][31:0];
                s_tlast[i]          = inq[i][0][32];
                s_tuser[i]          = inq[i][0][33];
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
                s_tuser[i]  = 1'b0;
            end
        end
        m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        cur = {m_tuser, m_tlast, m_tdata};
        if (stall_prev) chk("hold", {m_tvalid, cur}, {1'b1, prev_beat});
        chk("onehot", {$onehot0(grant), $onehot0(s_tready), |(s_tready & ~grant)}, 3'b110);
`ifdef ARB_TIMEOUT_EN
        if (timeout_pulse) begin
            tmo_n++;
            chk("tmo_beat", {m_tvalid, cur}, {1'b1, 2'b11, 32'h0});
        end
`else
        chk("tmo_idle", timeout_pulse, 0);
`endif
        if (m_tvalid && m_tready) begin
            if (expq.size() == 0) begin
                chk("unexpected_beat", expq.size(), 1);
            end else begin
                expb = expq.pop_front();
                chk("data", cur, expb);
            end
            outlog.push_back(cur);
            out_cyc.push_back(cyc);
        end
        acc = s_tvalid & s_tready;
        if (|acc) in_acc_cyc = cyc;
        rdy_snap      = s_tready;
        grant_snap    = grant;
        in1_left_snap = inq[1].size();
        stall_prev    = m_tvalid && !m_tready;
        prev_beat     = cur;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (acc[i]) void'(inq[i].pop_front());
    endtask

    task automatic drain(input string tag, input int maxc);
        int n;
        n = 0;
        while (pending() > 0 && n < maxc) begin
            step();
            n++;
        end
        chk({tag, "_drain"}, pending(), 0);
        step();
        step();
    endtask

    initial begin
        int total;
        int len;
        beat_t b;

        // T1: reset values, then reset in the middle of a packet
        repeat (2) @(posedge clk);
        chk("rst_por", {m_tvalid, m_tlast, m_tuser, m_tdata, grant, s_tready, timeout_pulse}, 0);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            b = mk(1'b0, k == 5, 32'h2000_0000 | k);
            inq[2].push_back(b);
            expq.push_back(b);
        end
        repeat (3) step();
        rst_n = 1'b0;
        #1;
        chk("rst_mid", {m_tvalid, m_tlast, m_tuser, m_tdata, grant, s_tready, timeout_pulse}, 0);
        for (int i = 0; i < N; i++) inq[i].delete();
        expq.delete();
        stall_prev = 1'b0;
        s_tvalid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // T2: all four inputs at once, 3 beats each
        outlog.delete();
        out_cyc.delete();
        for (int i = 0; i < N; i++)
            for (int k = 1; k <= 3; k++) begin
                b = mk(1'b0, k == 3, (32'(i) << 28) | 32'(k));
                inq[i].push_back(b);
                expq.push_back(b);
            end
        step();
        step();
        chk("t1_first_grant", grant_snap, 4'b0001);
        drain("t2", 200);
        chk("t2_count", outlog.size(), 12);
        for (int k = 1; k < outlog.size(); k++)
            chk("t2_gap", out_cyc[k] - out_cyc[k-1], outlog[k-1][32] ? 2 : 1);

        // T3: in1 8-beat packet, in2 shows up during it
        for (int k = 1; k <= 8; k++) begin
            b = mk(1'b0, k == 8, 32'h1000_0000 | k);
            inq[1].push_back(b);
            expq.push_back(b);
        end
        for (int k = 1; k <= 3; k++) expq.push_back(mk(1'b0, k == 3, 32'h2000_0000 | k));
        begin
            bit pushed;
            int n;
            pushed = 1'b0;
            n = 0;
            while ((pending() > 0) && n < 200) begin
                step();
                n++;
                if (in1_left_snap > 0) chk("t3_rdy2", rdy_snap[2], 0);
                if (!pushed && inq[1].size() <= 6) begin
                    for (int k = 1; k <= 3; k++) inq[2].push_back(mk(1'b0, k == 3, 32'h2000_0000 | k));
                    pushed = 1'b1;
                end
            end
            chk("t3_drain", pending(), 0);
        end

        // T5: single-beat packet with tuser on in3
        outlog.delete();
        out_cyc.delete();
        b = mk(1'b1, 1'b1, 32'hDEAD_BEEF);
        inq[3].push_back(b);
        expq.push_back(b);
        drain("t5", 50);
        chk("t5_count", outlog.size(), 1);
        chk("t5_beat", outlog[0], {2'b11, 32'hDEAD_BEEF});
        chk("t5_lat", out_cyc[0] - in_acc_cyc, 1);

        // T4: 100 random packets, all inputs backlogged, random back-pressure
        outlog.delete();
        out_cyc.delete();
        total = 0;
        for (int j = 0; j < 25; j++)
            for (int i = 0; i < N; i++) begin
                len = $urandom_range(1, 16);
                for (int k = 0; k < len; k++) begin
                    b = mk(1'($urandom_range(0, 1)), k == len - 1, $urandom);
                    inq[i].push_back(b);
                    expq.push_back(b);
                    total++;
                end
            end
        rnd_ready = 1'b1;
        drain("t4", 20000);
        rnd_ready = 1'b0;
        chk("t4_count", outlog.size(), total);

`ifdef ARB_TIMEOUT_EN
        // T6: in0 stalls after 2 beats, in1 waits behind it
        outlog.delete();
        out_cyc.delete();
        tmo_n = 0;
        inq[0].push_back(mk(1'b0, 1'b0, 32'h0000_0001));
        inq[0].push_back(mk(1'b0, 1'b0, 32'h0000_0002));
        expq.push_back(mk(1'b0, 1'b0, 32'h0000_0001));
        expq.push_back(mk(1'b0, 1'b0, 32'h0000_0002));
        expq.push_back(mk(1'b1, 1'b1, 32'h0));
        for (int k = 1; k <= 2; k++) begin
            b = mk(1'b0, k == 2, 32'h1000_0000 | k);
            inq[1].push_back(b);
            expq.push_back(b);
        end
        drain("t6", 100);
        chk("t6_pulses", tmo_n, 1);
        chk("t6_stall", out_cyc[2] - out_cyc[1], 10);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
